nios_pio_in: RTL and testbench

NIOS_PIO_IN -- requirements
Module: nios_pio_in

---
 rtl/nios_pio_in.sv | 187 ++++++++++++++++++
 tb/tb_nios_pio_in.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/nios_pio_in.sv
// nios_pio_in: Avalon-MM parallel input port with edge capture and a level IRQ.
//
// External inputs are double-flopped, optionally debounced, and presented as
// the "data" register. Edges on data (rising, falling or any, chosen by
// EDGE_TYPE) set sticky bits in edgecapture, which software clears by writing
// ones. irq is the OR of edgecapture masked by irqmask.
//
// Register map (address):
//   0 data        read-only, writes ignored
//   1 reserved    reads 0, writes ignored
//   2 irqmask     read/write, WIDTH bits
//   3 edgecapture read; write 1 to clear a bit (a same-cycle new edge wins)
//
// Bus handshake: there is no wait-state signalling. A write takes effect on
// the rising clk edge where chipselect=1 and write=1. readdata is registered
// every cycle from the current address, so it shows the addressed register
// one cycle after the address is presented; reads have no side effects.
//
// Optional build macro: NIOS_PIO_IN_DEBOUNCE_EN adds a per-bit stability
// counter between the synchronizer and the data register. Without it, data
// is simply the second synchronizer stage.

module nios_pio_in #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Synchronizer stages
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  // Filtered input value and its one-cycle-old copy for edge detection
  logic [WIDTH-1:0] w_data;
  logic [WIDTH-1:0] r_data_prev;

  // Software-visible state
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecapture;
  logic [31:0]      r_readdata;

  // Bus decode and edge detection
  logic             w_wr_en;
  logic             w_wr_mask;
  logic             w_wr_edge;
  logic [WIDTH-1:0] w_clr_bits;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_edgecapture_nxt;
  logic [31:0]      w_rd_mux;

  // Upper writedata bits are intentionally ignored when WIDTH < 32
  logic             w_unused_wdata;
  assign w_unused_wdata = &{1'b0, writedata};

  // Two-flop synchronizer for the asynchronous external inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= in_port;
      r_s2 <= r_s1;
    end
  end

`ifdef NIOS_PIO_IN_DEBOUNCE_EN
  // Counter reaches this value on the last differing cycle before data flips
  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_data;
  logic [15:0]      r_cnt [WIDTH];

  // Per-bit debounce: data follows s2 only after it has differed for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_s2[i] == r_data[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_data[i] <= r_s2[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign w_data = r_data;
`else
  assign w_data = r_s2;
`endif

  // Previous data value, used to detect transitions
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_prev <= '0;
    end else begin
      r_data_prev <= w_data;
    end
  end

  // Edge condition per bit, selected at elaboration by EDGE_TYPE
  always_comb begin
    w_edge = '0;
    case (EDGE_TYPE)
      0:       w_edge = w_data & ~r_data_prev;
      1:       w_edge = ~w_data & r_data_prev;
      default: w_edge = w_data ^ r_data_prev;
    endcase
  end

  // Write decode: chipselect qualifies every write
  assign w_wr_en    = chipselect & write;
  assign w_wr_mask  = w_wr_en & (address == ADDR_MASK);
  assign w_wr_edge  = w_wr_en & (address == ADDR_EDGE);
  assign w_clr_bits = w_wr_edge ? writedata[WIDTH-1:0] : '0;

  // Clear first, then OR in new edges so a same-cycle edge survives the clear
  assign w_edgecapture_nxt = (r_edgecapture & ~w_clr_bits) | w_edge;

  // Interrupt mask register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqmask <= '0;
    end else if (w_wr_mask) begin
      r_irqmask <= writedata[WIDTH-1:0];
    end
  end

  // Sticky edge capture register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edgecapture <= '0;
    end else begin
      r_edgecapture <= w_edgecapture_nxt;
    end
  end

  // Read mux: addressed register zero-extended to 32 bits
  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA: w_rd_mux[WIDTH-1:0] = w_data;
      ADDR_RSVD: w_rd_mux            = '0;
      ADDR_MASK: w_rd_mux[WIDTH-1:0] = r_irqmask;
      ADDR_EDGE: w_rd_mux[WIDTH-1:0] = r_edgecapture;
      default:   w_rd_mux            = '0;
    endcase
  end

  // Registered read data, refreshed every cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;

  // irq depends only on registers, never directly on bus inputs
  assign irq = |(r_edgecapture & r_irqmask);

endmodule

// File: tb/tb_nios_pio_in.sv
// Testbench for nios_pio_in: a 4-bit rising-edge instance and a 32-bit
// any-edge instance share clock and reset. Inputs are driven right after the
// falling edge and outputs are checked at the following falling edge.

module tb_nios_pio_in;

`ifdef NIOS_PIO_IN_DEBOUNCE_EN
  localparam int EXTRA = 16;
`else
  localparam int EXTRA = 0;
`endif

  // Clock and reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // 4-bit instance, rising edge
  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  // 32-bit instance, any edge
  logic [1:0]  address_32;
  logic        chipselect_32;
  logic        write_32;
  logic [31:0] writedata_32;
  logic [31:0] in_port_32;
  logic [31:0] readdata_32;
  logic        irq_32;

  nios_pio_in #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write      (write),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  nios_pio_in #(.WIDTH(32), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)) u_dut_32 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address_32),
    .chipselect (chipselect_32),
    .write      (write_32),
    .writedata  (writedata_32),
    .in_port    (in_port_32),
    .readdata   (readdata_32),
    .irq        (irq_32)
  );

  // Scoreboard
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bus write: called at a falling edge, returns at the next falling edge
  task automatic wr(input bit big, input logic [1:0] a, input logic [31:0] d);
    if (big) begin
      address_32 = a; writedata_32 = d; chipselect_32 = 1'b1; write_32 = 1'b1;
    end else begin
      address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    end
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; chipselect_32 = 1'b0; write_32 = 1'b0;
  endtask

  // Bus read: expectation queued when the address is driven, compared when
  // readdata appears one clock later
  task automatic rd(input bit big, input logic [1:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    exp_q.push_back(exp);
    if (big) address_32 = a; else address = a;
    @(negedge clk);
    e = exp_q.pop_front();
    check(tag, big ? readdata_32 : readdata, e);
  endtask

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    address = '0; chipselect = 1'b0; write = 1'b0; writedata = '0; in_port = 4'hF;
    address_32 = '0; chipselect_32 = 1'b0; write_32 = 1'b0; writedata_32 = '0;
    in_port_32 = '0;

    // Reset state with inputs high
    idle(3);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_readdata_32", readdata_32, 32'h0);

    // Release: inputs at 0xF appear after sync and are seen as rising edges
    reset_n = 1'b1;
    idle(4 + EXTRA);
    rd(0, 2'd0, 32'h0000_000F, "data_after_rst");
    rd(0, 2'd3, 32'h0000_000F, "ec_after_rst");
    check("irq_mask0", {31'h0, irq}, 32'h0);
    wr(0, 2'd3, 32'hF);
    rd(0, 2'd3, 32'h0, "ec_clear_all");

    // Falling edges are ignored in rising mode
    in_port = 4'h0;
    idle(4 + EXTRA);
    rd(0, 2'd3, 32'h0, "no_fall_capture");

    // Edge on bit1 with irqmask=0x2, exact irq latency
    wr(0, 2'd2, 32'h2);
    rd(0, 2'd2, 32'h2, "irqmask_rd");
    in_port = 4'h2;
    idle(2 + EXTRA);
    check("irq_early", {31'h0, irq}, 32'h0);
    idle(1);
    check("irq_latency", {31'h0, irq}, 32'h1);
    rd(0, 2'd3, 32'h2, "ec_bit1");
    wr(0, 2'd3, 32'h2);
    check("irq_after_clr", {31'h0, irq}, 32'h0);
    rd(0, 2'd3, 32'h0, "ec_bit1_clr");

    // Masked edge on bit0, then unmask
    wr(0, 2'd2, 32'h0);
    in_port = 4'h3;
    idle(4 + EXTRA);
    check("irq_masked", {31'h0, irq}, 32'h0);
    rd(0, 2'd3, 32'h1, "ec_bit0_masked");
    wr(0, 2'd2, 32'h1);
    check("irq_unmask", {31'h0, irq}, 32'h1);
    wr(0, 2'd3, 32'h1);
    check("irq_clr_bit0", {31'h0, irq}, 32'h0);

    // Write without chipselect is ignored
    address = 2'd2; writedata = 32'hF; write = 1'b1; chipselect = 1'b0;
    idle(1);
    write = 1'b0;
    rd(0, 2'd2, 32'h1, "cs_gate");

    // Read-only data, reserved address, zero upper bits
    wr(0, 2'd0, 32'h0);
    rd(0, 2'd0, 32'h3, "data_ro");
    wr(0, 2'd1, 32'hFFFF_FFFF);
    rd(0, 2'd1, 32'h0, "reserved");
    wr(0, 2'd2, 32'hFFFF_FFFF);
    rd(0, 2'd2, 32'h0000_000F, "mask_upper_zero");
    wr(0, 2'd2, 32'h0);

    // Set wins over clear: bit2 edge lands on the same clock as a 0xF clear
    in_port = 4'h7;
    idle(2 + EXTRA);
    wr(0, 2'd3, 32'hF);
    rd(0, 2'd3, 32'h4, "set_vs_clear");

    // Asynchronous reset with a pending edge
    wr(0, 2'd2, 32'h4);
    check("irq_pending", {31'h0, irq}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_readdata", readdata, 32'h0);
    check("async_rst_irq", {31'h0, irq}, 32'h0);
    in_port = 4'h0;
    @(negedge clk);
    reset_n = 1'b1;
    idle(4 + EXTRA);
    rd(0, 2'd3, 32'h0, "no_edge_after_rst");
    rd(0, 2'd2, 32'h0, "mask_after_rst");

`ifdef NIOS_PIO_IN_DEBOUNCE_EN
    // Short glitch is filtered; a long level flips data after 16 cycles
    in_port = 4'h8;
    idle(10);
    in_port = 4'h0;
    idle(20);
    rd(0, 2'd0, 32'h0, "glitch_data");
    rd(0, 2'd3, 32'h0, "glitch_ec");
    in_port = 4'h8;
    idle(17);
    rd(0, 2'd0, 32'h0, "db_not_yet");
    rd(0, 2'd0, 32'h8, "db_exact");
    idle(2);
`endif

    // 32-bit any-edge instance
    in_port_32 = 32'hFFFF_FFFF;
    idle(4 + EXTRA);
    rd(1, 2'd3, 32'hFFFF_FFFF, "any_rise_32");
    rd(1, 2'd0, 32'hFFFF_FFFF, "data_32");
    wr(1, 2'd3, 32'hFFFF_FFFF);
    rd(1, 2'd3, 32'h0, "clr_32");
    in_port_32 = 32'h0;
    idle(4 + EXTRA);
    rd(1, 2'd3, 32'hFFFF_FFFF, "any_fall_32");
    rd(1, 2'd1, 32'h0, "reserved_32");
    wr(1, 2'd2, 32'h8000_0000);
    check("irq_32", {31'h0, irq_32}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
